div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter TIMEOUT, default 40: maximum RUN cycles to wait for div_resultRDY.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ctrl_DIV, input, 1: divide request from the pipeline, sampled on each clock edge.
REQ-006 SHALL have port data_operandA, input, WIDTH: dividend, valid with ctrl_DIV.
REQ-007 SHALL have port data_operandB, input, WIDTH: divisor, valid with ctrl_DIV.
REQ-008 SHALL have port stall, output, 1: pipeline hold; high in LAUNCH and RUN.
REQ-009 SHALL have port data_result, output, WIDTH: registered quotient.
REQ-010 SHALL have port data_resultRDY, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port data_exception, output, 1: error flag, valid with data_resultRDY and held until the next completion.
REQ-012 SHALL have port div_operandA, output, WIDTH: latched dividend to the divider.
REQ-013 SHALL have port div_operandB, output, WIDTH: latched divisor to the divider.
REQ-014 SHALL have port div_rst, output, 1: active-high divider restart.
REQ-015 SHALL have port div_result, input, WIDTH: divider quotient.
REQ-016 SHALL have port div_resultRDY, input, 1: divider done.
REQ-017 SHALL have port div_exception, input, 1: divider divide-by-zero.

Function
REQ-018 SHALL implement an FSM with states IDLE, LAUNCH, RUN and DONE.
REQ-019 In IDLE or DONE, a sampled ctrl_DIV=1 SHALL capture data_operandA/B into div_operandA/B and move to LAUNCH; otherwise the FSM SHALL go to (or stay in) IDLE.
REQ-020 ctrl_DIV SHALL be ignored in LAUNCH and RUN; div_operandA/B SHALL stay stable from capture until the next capture.
REQ-021 LAUNCH SHALL last exactly one cycle with div_rst=1, then go to RUN; div_rst SHALL be 0 in all other states.
REQ-022 In RUN, div_resultRDY and div_exception SHALL be sampled each cycle, including the first RUN cycle; both SHALL be ignored in LAUNCH.
REQ-023 A sampled div_resultRDY=1 in RUN SHALL register div_result into data_result and div_exception into data_exception, then go to DONE.
REQ-024 If div_exception=1 at that edge, data_result SHALL be loaded with 0, not div_result.
REQ-025 A RUN-cycle counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-026 If the counter reaches TIMEOUT with no div_resultRDY, the FSM SHALL go to DONE with data_result=0 and data_exception=1.
REQ-027 The counter SHALL be wide enough to hold TIMEOUT without wrapping.
REQ-028 data_resultRDY SHALL be 1 exactly in DONE, for one cycle per request.
REQ-029 Latency from ctrl_DIV sampling edge to data_resultRDY SHALL be N+2 cycles, where N is the RUN cycle (1-based) in which div_resultRDY is first seen.
REQ-030 stall SHALL rise in the cycle after ctrl_DIV is sampled and fall in the DONE cycle, giving back-to-back requests with no IDLE gap.

Reset
REQ-031 With rst=0, asynchronously: FSM=IDLE, counter=0, stall=0, data_resultRDY=0, data_exception=0, data_result=0, div_operandA/B=0, div_rst=0.
REQ-032 Reset asserted mid-operation SHALL abort with no data_resultRDY pulse.
REQ-033 The first ctrl_DIV after reset release SHALL be handled normally.

Verification
REQ-034 A=100, B=7, model RDY in RUN cycle 33 -> stall high cycles 1-34, data_resultRDY pulse cycle 35, data_result=14, data_exception=0.
REQ-035 A=5, B=0, model exception+RDY in RUN cycle 1 -> data_resultRDY cycle 3, data_result=0, data_exception=1.
REQ-036 Model never asserts RDY -> data_resultRDY after TIMEOUT RUN cycles, data_result=0, data_exception=1.
REQ-037 ctrl_DIV pulsed in RUN with new operands -> ignored; div_operandA/B unchanged; one completion only.
REQ-038 ctrl_DIV=1 during DONE (A=9, B=3) -> first result presented, LAUNCH next cycle, second result=3.
REQ-039 rst=0 in RUN cycle 10 -> all outputs zero immediately, no data_resultRDY, next request completes normally.

Source files
------------

// File: rtl/div_ctrl.sv
// Divide-request sequencer: latches operands, restarts an external divider,
// waits (bounded) for its completion and presents a registered result to the pipeline.
module div_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             stall,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic [WIDTH-1:0] div_operandA,
  output logic [WIDTH-1:0] div_operandB,
  output logic             div_rst,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_resultRDY,
  input  logic             div_exception
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Outputs are set on the transition into the state they belong to, so they
  // are registered yet line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      stall          <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      div_operandA   <= '0;
      div_operandB   <= '0;
      div_rst        <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      div_rst        <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctrl_DIV) begin
            state        <= LAUNCH;
            div_operandA <= data_operandA;
            div_operandB <= data_operandB;
            stall        <= 1'b1;
            div_rst      <= 1'b1;
          end else begin
            state <= IDLE;
            stall <= 1'b0;
          end
        end
        LAUNCH: begin
          state <= RUN;
          cnt   <= '0;
          stall <= 1'b1;
        end
        RUN: begin
          // A completion seen in the last allowed cycle wins over the timeout.
          if (div_resultRDY) begin
            state          <= DONE;
            data_result    <= div_exception ? '0 : div_result;
            data_exception <= div_exception;
            data_resultRDY <= 1'b1;
            stall          <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state          <= DONE;
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            stall          <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider that answers in a chosen RUN cycle.
module tb_div_ctrl;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] opa, opb;
  logic             stall;
  logic [WIDTH-1:0] data_result;
  logic             data_resultRDY;
  logic             data_exception;
  logic [WIDTH-1:0] div_operandA, div_operandB;
  logic             div_rst;
  logic [WIDTH-1:0] div_result;
  logic             div_resultRDY;
  logic             div_exception;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ctrl_DIV(ctrl_DIV),
    .data_operandA(opa), .data_operandB(opb),
    .stall(stall), .data_result(data_result), .data_resultRDY(data_resultRDY),
    .data_exception(data_exception),
    .div_operandA(div_operandA), .div_operandB(div_operandB), .div_rst(div_rst),
    .div_result(div_result), .div_resultRDY(div_resultRDY), .div_exception(div_exception)
  );

  // Divider model: counts RUN cycles after a restart and pulses ready when the count hits model_n.
  logic [15:0] model_n = '0;
  logic        model_exc = 1'b0;
  logic [15:0] mcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) mcnt <= '0;
    else if (div_rst) mcnt <= 16'd1;
    else if (mcnt != 16'd0 && !div_resultRDY) mcnt <= mcnt + 16'd1;
    else mcnt <= '0;
  end

  assign div_resultRDY = (model_n != 16'd0) && (mcnt == model_n);
  assign div_exception = model_exc;
  assign div_result    = model_exc ? 32'hDEAD_BEEF :
                         (div_operandB == '0) ? '0 : div_operandA / div_operandB;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issues one request and returns in the completion cycle (or after the cycle budget).
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [15:0] n,
                        input logic exc, output int lat, output logic [31:0] res,
                        output logic ex, output int bad);
    bad = 0; lat = 0; res = 'x; ex = 1'bx;
    @(negedge clk);
    ctrl_DIV = 1'b1; opa = a; opb = b; model_n = n; model_exc = exc;
    @(posedge clk); #1;
    ctrl_DIV = 1'b0; opa = $urandom; opb = $urandom;
    for (int c = 1; c <= 200; c++) begin
      if (data_resultRDY) begin
        lat = c; res = data_result; ex = data_exception;
        if (stall) bad++;
        break;
      end
      if (!stall) bad++;
      if (div_rst !== (c == 1)) bad++;
      if (div_operandA !== a || div_operandB !== b) bad++;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] n;
    logic        exc;
    logic [31:0] q;
    logic        ex;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, bad, pulses;
    logic [31:0] res;
    logic ex;

    vecs[0] = '{a: 32'd100,        b: 32'd7,  n: 16'd33, exc: 1'b0, q: 32'd14,         ex: 1'b0, lat: 35};
    vecs[1] = '{a: 32'd5,          b: 32'd0,  n: 16'd1,  exc: 1'b1, q: 32'd0,          ex: 1'b1, lat: 3};
    vecs[2] = '{a: 32'd123,        b: 32'd4,  n: 16'd0,  exc: 1'b0, q: 32'd0,          ex: 1'b1, lat: 42};
    vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'd1,  n: 16'd1,  exc: 1'b0, q: 32'hFFFF_FFFF,  ex: 1'b0, lat: 3};
    vecs[4] = '{a: 32'd1000,       b: 32'd10, n: 16'd40, exc: 1'b0, q: 32'd100,        ex: 1'b0, lat: 42};
    vecs[5] = '{a: 32'd1000,       b: 32'd10, n: 16'd41, exc: 1'b0, q: 32'd0,          ex: 1'b1, lat: 42};
    vecs[6] = '{a: 32'd7,          b: 32'd9,  n: 16'd2,  exc: 1'b0, q: 32'd0,          ex: 1'b0, lat: 4};

    rst = 1'b0; ctrl_DIV = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {31'd0, stall, data_result, data_resultRDY, data_exception, div_rst},
        64'd0);
    chk("reset_operands", {div_operandA, div_operandB}, 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exc, lat, res, ex, bad);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), 64'(res), 64'(vecs[i].q));
      chk($sformatf("v%0d_exception", i), 64'(ex), 64'(vecs[i].ex));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bad), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_single_pulse", i), {62'd0, data_resultRDY, stall}, 64'd0);
      chk($sformatf("v%0d_exc_held", i), 64'(data_exception), 64'(vecs[i].ex));
    end

    // Request arriving in the DONE cycle launches immediately.
    do_req(32'd20, 32'd4, 16'd2, 1'b0, lat, res, ex, bad);
    chk("b2b_first_latency", 64'(lat), 64'd4);
    chk("b2b_first_result", 64'(res), 64'd5);
    ctrl_DIV = 1'b1; opa = 32'd9; opb = 32'd3; model_n = 16'd1; model_exc = 1'b0;
    @(posedge clk); #1;
    ctrl_DIV = 1'b0;
    chk("b2b_launch", {60'd0, stall, div_rst, data_resultRDY, 1'b0}, 64'hC);
    chk("b2b_operands", {div_operandA, div_operandB}, {32'd9, 32'd3});
    chk("b2b_result_held", 64'(data_result), 64'd5);
    @(posedge clk); #1;
    chk("b2b_run1", {62'd0, stall, data_resultRDY}, 64'h2);
    @(posedge clk); #1;
    chk("b2b_second", {30'd0, stall, data_resultRDY, data_result}, {32'h1, 32'd3});

    // Request during RUN is ignored and operands stay put.
    @(negedge clk);
    ctrl_DIV = 1'b1; opa = 32'd50; opb = 32'd5; model_n = 16'd8; model_exc = 1'b0;
    @(posedge clk); #1;
    ctrl_DIV = 1'b0;
    pulses = 0; lat = 0; bad = 0; res = 'x;
    for (int c = 1; c <= 20; c++) begin
      if (c == 6) begin ctrl_DIV = 1'b1; opa = 32'd1; opb = 32'd1; end
      if (c == 7) ctrl_DIV = 1'b0;
      if (data_resultRDY) begin pulses++; lat = c; res = data_result; end
      if (div_operandA !== 32'd50 || div_operandB !== 32'd5) bad++;
      @(posedge clk); #1;
    end
    chk("ignore_pulses", 64'(pulses), 64'd1);
    chk("ignore_latency", 64'(lat), 64'd10);
    chk("ignore_result", 64'(res), 64'd10);
    chk("ignore_operands", 64'(bad), 64'd0);

    // Reset in RUN cycle 10 aborts silently.
    @(negedge clk);
    ctrl_DIV = 1'b1; opa = 32'd77; opb = 32'd7; model_n = 16'd20; model_exc = 1'b0;
    @(posedge clk); #1;
    ctrl_DIV = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_pre_stall", 64'(stall), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_outputs",
        {31'd0, stall, data_result, data_resultRDY, data_exception, div_rst}, 64'd0);
    chk("abort_operands", {div_operandA, div_operandB}, 64'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (data_resultRDY) pulses++;
    end
    @(negedge clk); rst = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (data_resultRDY) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    do_req(32'd77, 32'd7, 16'd3, 1'b0, lat, res, ex, bad);
    chk("post_reset_latency", 64'(lat), 64'd5);
    chk("post_reset_result", {31'd0, ex, res}, {32'd0, 32'd11});
    chk("post_reset_busy", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
